pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It turns EX-stage events into per-stage stall, flush and bubble controls: taken branch/jump, load-use hazard against the ID instruction, multi-cycle RV32M operations held in EX, and data-memory wait. It sits beside the datapath. It reads the IF/ID and ID/EX instruction registers plus the EX branch decision, and drives the enables of the PC and pipeline registers.

## Interface
Parameters:
- DIV_LAT, 32, EX busy cycles for DIV/DIVU/REM/REMU; legal range 2..64.
- MUL_LAT, 1, EX busy cycles for MUL/MULH/MULHSU/MULHU; 1 means single-cycle with no stall; legal range 1..64.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_instr_i  in  32  instruction in IF/ID register.
- ex_instr_i  in  32  instruction in ID/EX register, the one currently in EX.
- ex_wbaddr_i  in  5  rd of the EX instruction.
- jump_en_i  in  1  EX branch/jump taken.
- mem_wait_i  in  1  data memory not ready; freeze the whole pipeline.
- stall_if_o  out  1  hold PC.
- stall_id_o  out  1  hold IF/ID.
- stall_ex_o  out  1  hold ID/EX and EX/MEM inputs.
- flush_id_o  out  1  load NOP (0x00000013) into IF/ID.
- bubble_ex_o  out  1  load NOP into ID/EX.
- md_start_o  out  1  one-cycle pulse that starts the M-unit.
- md_busy_o  out  1  M-operation in progress.
- md_done_o  out  1  one-cycle pulse; M-unit result is valid on this cycle.

## Operation
Decode rules:
- An M-op is opcode 0110011 with funct7 0000001. funct3[2]=1 selects DIV_LAT; funct3[2]=0 selects MUL_LAT.
- A load is opcode 0000011.
- ID rs1 is used by every opcode except LUI, AUIPC and JAL.
- ID rs2 is used by R-type, STORE and BRANCH only.
- A load-use hazard exists when EX holds a load, ex_wbaddr_i != 0, and a used ID rs field equals ex_wbaddr_i.

FSM states: RUN, MD_BUSY, MD_DONE.
- RUN → MD_BUSY when EX holds an M-op with latency > 1 and mem_wait_i=0. On that cycle md_start_o=1 and cnt ← LAT-1.
- MD_BUSY: cnt decrements each cycle. When cnt reaches 1, go to MD_DONE.
- MD_DONE: md_done_o=1 for one cycle, then go to RUN. If mem_wait_i=1, stay in MD_DONE and keep md_done_o high.
- Net effect: an M-op with latency L occupies EX for exactly L cycles.

Output priority, highest first:
1. mem_wait_i=1: all three stalls=1; flush and bubble=0; FSM and counter keep advancing, except that MD_DONE is held as above.
2. MD_BUSY, or the RUN cycle that launches an M-op: all three stalls=1; md_busy_o=1.
3. jump_en_i=1: flush_id_o=1 and bubble_ex_o=1; no stalls. Exactly two wrong-path instructions are discarded.
4. Load-use hazard: stall_if_o=1, stall_id_o=1, bubble_ex_o=1 for exactly one cycle.
5. Otherwise all controls are 0.

Simultaneous events:
- jump_en_i together with a load-use hazard: the jump wins and no stall is issued.
- An M-op in EX with latency 1: no FSM activity and no stall.

## Timing
- All control outputs are combinational from the current inputs and state. The pipeline registers consume them at the next rising edge.
- md_start_o is asserted in the first cycle the M-op is in EX. md_done_o is asserted in its last cycle, and the result is written to EX/MEM at the end of that cycle.
- Back-to-back M-ops: the second M-op enters EX the cycle after MD_DONE and restarts the sequence at once; there is no dead cycle.
- Reset (reset=0) asynchronously returns the FSM to RUN, sets cnt=0, and drives every output to 0. Reset asserted mid-M-op aborts it with no md_done_o pulse.
- Counter width is $clog2(64)+1 = 7 bits. It never underflows: entering MD_BUSY requires LAT ≥ 2.

## Structure
- Shared package pipe_pkg:
  - opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_OP;
  - FUNCT7_MULDIV;
  - INSTR_NOP = 32'h00000013;
  - the FSM state enum.
- One sub-module, hazard_detect: combinational rs-usage decode and load-use compare.
- The FSM, counter and priority logic live in pipe_ctrl.

## Test plan
- Load x5 in EX, ID holds `add x6,x5,x1` → one cycle with stall_if_o=stall_id_o=bubble_ex_o=1, then all 0. Repeat with the ID holding `lui x5,…`: no stall.
- jump_en_i=1 for one cycle → flush_id_o=bubble_ex_o=1 for that cycle only. Repeat with a simultaneous load-use hazard: no stall asserted.
- DIV in EX with DIV_LAT=32 → md_start_o on cycle 0, stalls high on cycles 0–30, md_done_o on cycle 31, RUN on cycle 32. Repeat with MUL and MUL_LAT=1: no stall.
- mem_wait_i held for 3 cycles while in MD_DONE → md_done_o held high for 4 cycles, all stalls=1 during the wait.
- Reset pulled low on cycle 10 of a DIV → all outputs 0 immediately; after release, state RUN and no md_done_o.
- Two consecutive DIVs with DIV_LAT=4 → md_start_o on cycles 0 and 4, md_done_o on cycles 3 and 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared RV32 decode constants and controller state encoding for the pipeline sequencer.
package pipe_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0]  FUNCT7_MULDIV = 7'b0000001;
    localparam logic [31:0] INSTR_NOP     = 32'h00000013;

    // Wide enough to hold the largest legal latency (64).
    localparam int CNT_W = $clog2(64) + 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_MD_DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: decodes which rs fields the ID instruction reads
// and compares them against the rd of a load sitting in EX.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [31:0] id_instr,
    input  logic [6:0]  ex_opcode,
    input  logic [4:0]  ex_wbaddr,
    output logic        load_use
);

    logic [6:0] id_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_id_bits;

    assign id_op          = id_instr[6:0];
    assign rs1            = id_instr[19:15];
    assign rs2            = id_instr[24:20];
    assign unused_id_bits = ^{id_instr[31:25], id_instr[14:7]};

    always_comb begin
        rs1_used = !((id_op == OP_LUI) || (id_op == OP_AUIPC) || (id_op == OP_JAL));
        rs2_used = (id_op == OP_OP) || (id_op == OP_STORE) || (id_op == OP_BRANCH);
        rs1_hit  = rs1_used && (rs1 == ex_wbaddr);
        rs2_hit  = rs2_used && (rs2 == ex_wbaddr);
        // x0 is never a real dependency, so a load into x0 never stalls.
        load_use = (ex_opcode == OP_LOAD) && (ex_wbaddr != 5'd0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns EX-stage events into per-stage
// stall/flush/bubble controls and sequences multi-cycle RV32M operations.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DIV_LAT = 32,
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] id_instr_i,
    input  logic [31:0] ex_instr_i,
    input  logic [4:0]  ex_wbaddr_i,
    input  logic        jump_en_i,
    input  logic        mem_wait_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        flush_id_o,
    output logic        bubble_ex_o,
    output logic        md_start_o,
    output logic        md_busy_o,
    output logic        md_done_o,
    output logic [1:0]  dbg_state_o
);

    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic             ex_is_md;
    logic             launch;
    logic             md_hold;
    logic             load_use;
    logic             unused_ex_bits;

    assign unused_ex_bits = ^{ex_instr_i[24:15], ex_instr_i[13:7]};

    hazard_detect u_hazard (
        .id_instr  (id_instr_i),
        .ex_opcode (ex_instr_i[6:0]),
        .ex_wbaddr (ex_wbaddr_i),
        .load_use  (load_use)
    );

    assign ex_is_md = (ex_instr_i[6:0] == OP_OP) && (ex_instr_i[31:25] == FUNCT7_MULDIV);
    assign lat      = ex_instr_i[14] ? DIV_CNT : MUL_CNT;
    // Single-cycle M-ops never touch the FSM; a launch waits out any memory stall.
    assign launch   = (state == ST_RUN) && ex_is_md && (lat > CNT_ONE) && !mem_wait_i;
    assign md_hold  = launch || (state == ST_MD_BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (launch) begin
                        cnt   <= lat - CNT_ONE;
                        // With latency 2 the launch cycle is already the
                        // second-to-last, so go straight to the done cycle.
                        state <= (lat == CNT_TWO) ? ST_MD_DONE : ST_MD_BUSY;
                    end
                end
                ST_MD_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_TWO) begin
                        state <= ST_MD_DONE;
                    end
                end
                ST_MD_DONE: begin
                    if (!mem_wait_i) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        flush_id_o  = 1'b0;
        bubble_ex_o = 1'b0;
        if (!reset) begin
            stall_if_o = 1'b0;
        end else if (mem_wait_i || md_hold) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            stall_ex_o = 1'b1;
        end else if (jump_en_i) begin
            flush_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end else if (load_use) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            bubble_ex_o = 1'b1;
        end
    end

    assign md_start_o  = reset && launch;
    assign md_busy_o   = reset && md_hold;
    assign md_done_o   = reset && (state == ST_MD_DONE);
    assign dbg_state_o = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (DIV_LAT=32 and DIV_LAT=4)
// share stimulus; per-cycle expectations are queued by the driver and checked on negedge.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int W = 10;

    // Field order: stall_if stall_id stall_ex flush bubble start busy done state[1:0]
    localparam logic [W-1:0] IDLE    = {8'b0000_0000, ST_RUN};
    localparam logic [W-1:0] LU      = {8'b1100_1000, ST_RUN};
    localparam logic [W-1:0] JMP     = {8'b0001_1000, ST_RUN};
    localparam logic [W-1:0] MW_RUN  = {8'b1110_0000, ST_RUN};
    localparam logic [W-1:0] LAUNCH  = {8'b1110_0110, ST_RUN};
    localparam logic [W-1:0] BUSY    = {8'b1110_0010, ST_MD_BUSY};
    localparam logic [W-1:0] DONE    = {8'b0000_0001, ST_MD_DONE};
    localparam logic [W-1:0] DONE_MW = {8'b1110_0001, ST_MD_DONE};

    localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD};
    localparam logic [31:0] LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, OP_LOAD};
    localparam logic [31:0] ADD_X6  = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, OP_OP};
    localparam logic [31:0] ADD_R2  = {7'd0, 5'd5, 5'd2, 3'b000, 5'd6, OP_OP};
    localparam logic [31:0] LUI_X5  = {7'd0, 5'd5, 5'd5, 3'b000, 5'd7, OP_LUI};
    localparam logic [31:0] JAL_X1  = {7'd0, 5'd5, 5'd5, 3'b000, 5'd1, OP_JAL};
    localparam logic [31:0] SW_X5   = {7'd0, 5'd5, 5'd2, 3'b010, 5'd0, OP_STORE};
    localparam logic [31:0] ADDI_R2 = {7'd0, 5'd5, 5'd1, 3'b000, 5'd7, 7'b0010011};
    localparam logic [31:0] DIV_A   = {FUNCT7_MULDIV, 5'd2, 5'd3, 3'b100, 5'd4, OP_OP};
    localparam logic [31:0] DIV_B   = {FUNCT7_MULDIV, 5'd6, 5'd7, 3'b101, 5'd8, OP_OP};
    localparam logic [31:0] MUL_A   = {FUNCT7_MULDIV, 5'd2, 5'd3, 3'b000, 5'd4, OP_OP};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] id_instr = INSTR_NOP;
    logic [31:0] ex_instr = INSTR_NOP;
    logic [4:0]  ex_wbaddr;
    logic        jump_en = 1'b0;
    logic        mem_wait = 1'b0;

    logic        a_sif, a_sid, a_sex, a_fl, a_bu, a_st, a_bs, a_dn;
    logic [1:0]  a_state;
    logic        b_sif, b_sid, b_sex, b_fl, b_bu, b_st, b_bs, b_dn;
    logic [1:0]  b_state;
    logic [W-1:0] obs_a;
    logic [W-1:0] obs_b;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    bit           sel_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign ex_wbaddr = ex_instr[11:7];
    assign obs_a = {a_sif, a_sid, a_sex, a_fl, a_bu, a_st, a_bs, a_dn, a_state};
    assign obs_b = {b_sif, b_sid, b_sex, b_fl, b_bu, b_st, b_bs, b_dn, b_state};

    pipe_ctrl #(.DIV_LAT(32), .MUL_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .id_instr_i(id_instr), .ex_instr_i(ex_instr),
        .ex_wbaddr_i(ex_wbaddr), .jump_en_i(jump_en), .mem_wait_i(mem_wait),
        .stall_if_o(a_sif), .stall_id_o(a_sid), .stall_ex_o(a_sex),
        .flush_id_o(a_fl), .bubble_ex_o(a_bu), .md_start_o(a_st),
        .md_busy_o(a_bs), .md_done_o(a_dn), .dbg_state_o(a_state)
    );

    pipe_ctrl #(.DIV_LAT(4), .MUL_LAT(1)) u_dut4 (
        .clk(clk), .reset(reset), .id_instr_i(id_instr), .ex_instr_i(ex_instr),
        .ex_wbaddr_i(ex_wbaddr), .jump_en_i(jump_en), .mem_wait_i(mem_wait),
        .stall_if_o(b_sif), .stall_id_o(b_sid), .stall_ex_o(b_sex),
        .flush_id_o(b_fl), .bubble_ex_o(b_bu), .md_start_o(b_st),
        .md_busy_o(b_bs), .md_done_o(b_dn), .dbg_state_o(b_state)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        string        t;
        bit           s;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            s = sel_q.pop_front();
            check_eq(t, s ? obs_b : obs_a, e);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input string tag, input logic [31:0] id, input logic [31:0] ex,
                         input logic jmp, input logic mw, input bit use_b,
                         input logic [W-1:0] exp);
        @(posedge clk);
        #1;
        id_instr = id;
        ex_instr = ex;
        jump_en  = jmp;
        mem_wait = mw;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        sel_q.push_back(use_b);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset    = 1'b0;
        id_instr = INSTR_NOP;
        ex_instr = INSTR_NOP;
        jump_en  = 1'b0;
        mem_wait = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1;
        check_eq("reset_a", obs_a, IDLE);
        check_eq("reset_b", obs_b, IDLE);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Load-use hazard and the rs-usage decode corners
        drive("lu_add",       ADD_X6,  LW_X5,     0, 0, 0, LU);
        drive("lu_clear",     ADD_X6,  INSTR_NOP, 0, 0, 0, IDLE);
        drive("lu_lui",       LUI_X5,  LW_X5,     0, 0, 0, IDLE);
        drive("lu_jal",       JAL_X1,  LW_X5,     0, 0, 0, IDLE);
        drive("lu_x0",        ADD_X6,  LW_X0,     0, 0, 0, IDLE);
        drive("lu_store_rs2", SW_X5,   LW_X5,     0, 0, 0, LU);
        drive("lu_rtype_rs2", ADD_R2,  LW_X5,     0, 0, 0, LU);
        drive("lu_itype_rs2", ADDI_R2, LW_X5,     0, 0, 0, IDLE);
        drive("lu_memwait",   ADD_X6,  LW_X5,     0, 1, 0, MW_RUN);

        // Jump, jump over a hazard, jump under memory wait
        drive("jmp",          INSTR_NOP, INSTR_NOP, 1, 0, 0, JMP);
        drive("jmp_clear",    INSTR_NOP, INSTR_NOP, 0, 0, 0, IDLE);
        drive("jmp_over_lu",  ADD_X6,    LW_X5,     1, 0, 0, JMP);
        drive("jmp_memwait",  INSTR_NOP, INSTR_NOP, 1, 1, 0, MW_RUN);
        drive("jmp_idle",     INSTR_NOP, INSTR_NOP, 0, 0, 0, IDLE);

        // Single DIV with latency 32
        apply_reset();
        for (int k = 0; k < 32; k++)
            drive($sformatf("div32_c%0d", k), INSTR_NOP, DIV_A, 0, 0, 0,
                  (k == 0) ? LAUNCH : ((k < 31) ? BUSY : DONE));
        drive("div32_c32", INSTR_NOP, INSTR_NOP, 0, 0, 0, IDLE);

        // Single-cycle MUL
        drive("mul_lat1",  INSTR_NOP, MUL_A,     0, 0, 0, IDLE);
        drive("mul_after", INSTR_NOP, INSTR_NOP, 0, 0, 0, IDLE);

        // Memory wait around a latency-4 DIV, including a held done cycle
        apply_reset();
        drive("mw_pre",   INSTR_NOP, DIV_A, 0, 1, 1, MW_RUN);
        drive("mw_c0",    INSTR_NOP, DIV_A, 0, 0, 1, LAUNCH);
        drive("mw_c1",    INSTR_NOP, DIV_A, 0, 1, 1, BUSY);
        drive("mw_c2",    INSTR_NOP, DIV_A, 0, 0, 1, BUSY);
        for (int k = 3; k < 6; k++)
            drive($sformatf("mw_c%0d", k), INSTR_NOP, DIV_A, 0, 1, 1, DONE_MW);
        drive("mw_c6",    INSTR_NOP, DIV_A,     0, 0, 1, DONE);
        drive("mw_c7",    INSTR_NOP, INSTR_NOP, 0, 0, 1, IDLE);

        // Back-to-back latency-4 DIVs
        apply_reset();
        for (int k = 0; k < 8; k++)
            drive($sformatf("b2b_c%0d", k), INSTR_NOP, (k < 4) ? DIV_A : DIV_B, 0, 0, 1,
                  ((k % 4) == 0) ? LAUNCH : (((k % 4) == 3) ? DONE : BUSY));
        drive("b2b_c8", INSTR_NOP, INSTR_NOP, 0, 0, 1, IDLE);

        // Reset in the middle of a latency-32 DIV
        apply_reset();
        for (int k = 0; k < 10; k++)
            drive($sformatf("rst_div_c%0d", k), INSTR_NOP, DIV_A, 0, 0, 0,
                  (k == 0) ? LAUNCH : BUSY);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_a", obs_a, IDLE);
        ex_instr = INSTR_NOP;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++)
            drive($sformatf("rst_after_c%0d", k), INSTR_NOP, INSTR_NOP, 0, 0, 0, IDLE);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
